// File: rtl/i2c_init_sequencer_pkg.sv
// Shared definitions for the I2C power-up sequencer: FSM states, table entry
// markers and default timing constants.
package i2c_init_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_GAP,
        ST_DELAY,
        ST_DONE,
        ST_ERROR
    } state_e;

    typedef enum logic [1:0] {
        ENT_WRITE,
        ENT_DELAY,
        ENT_END
    } entry_e;

    localparam logic [7:0] END_MARK   = 8'hFF;
    localparam logic [7:0] DELAY_MARK = 8'hFE;

    localparam int unsigned DEF_GAP_CLKS   = 100_000;
    localparam int unsigned DEF_DELAY_UNIT = 25_000;

    function automatic entry_e entry_kind(input logic [15:0] ent);
        if (ent[15:8] == END_MARK && ent[7:0] == END_MARK) return ENT_END;
        if (ent[15:8] == DELAY_MARK) return ENT_DELAY;
        return ENT_WRITE;
    endfunction

endpackage

// File: rtl/i2c_init_rom.sv
// Configuration table ROM: 2**ADDR_W entries of {register, data}, one cycle read latency.
// Entry 0 lives in IMAGE[15:0]; unused entries default to the END marker.
module i2c_init_rom #(
    parameter int unsigned                      ADDR_W = 6,
    parameter logic [16*(2**ADDR_W)-1:0]        IMAGE  = '1
) (
    input  logic              sda_clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [15:0]       data
);

    logic [15:0] data_q;
    logic [15:0] data_d;

    always_comb begin
        data_d = IMAGE[{addr, 4'b0000} +: 16];
    end

    always_ff @(posedge sda_clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the configuration table and issues one I2C byte write per entry, with
// inter-message gaps, programmable delays, NACK/timeout retries and done/error status.
module i2c_init_sequencer
    import i2c_init_sequencer_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = 7'h39,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned GAP_CLKS    = DEF_GAP_CLKS,
    parameter int unsigned DELAY_UNIT  = DEF_DELAY_UNIT,
    parameter int unsigned MAX_RETRIES = 3,
    parameter int unsigned RSP_TIMEOUT = 1_000_000
) (
    input  logic              sda_clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [15:0]       tbl_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [6:0]        cmd_dev_addr,
    output logic [7:0]        cmd_reg,
    output logic [7:0]        cmd_data,
    input  logic              rsp_valid,
    input  logic              rsp_nack,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_index
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [7:0]        cmd_reg_q, cmd_reg_d;
    logic [7:0]        cmd_data_q, cmd_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] err_index_q, err_index_d;
    logic [7:0]        retry_q, retry_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              adv_q, adv_d;
    logic              do_adv;

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        cmd_valid_d = cmd_valid_q;
        cmd_reg_d   = cmd_reg_q;
        cmd_data_d  = cmd_data_q;
        done_d      = done_q;
        error_d     = error_q;
        err_index_d = err_index_q;
        retry_d     = retry_q;
        cnt_d       = cnt_q;
        adv_d       = adv_q;
        do_adv      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    index_d = '0;
                    retry_d = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                case (entry_kind(tbl_data))
                    ENT_END: begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                    ENT_DELAY: begin
                        cnt_d   = 32'(tbl_data[7:0]) * 32'(DELAY_UNIT);
                        state_d = ST_DELAY;
                    end
                    default: begin
                        cmd_reg_d   = tbl_data[15:8];
                        cmd_data_d  = tbl_data[7:0];
                        cmd_valid_d = 1'b1;
                        state_d     = ST_ISSUE;
                    end
                endcase
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (rsp_valid && !rsp_nack) begin
                    retry_d = '0;
                    adv_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else if (rsp_valid || cnt_q == 32'(RSP_TIMEOUT - 1)) begin
                    // A silent slave is handled exactly like a NACK.
                    if (retry_q < 8'(MAX_RETRIES)) begin
                        retry_d = retry_q + 8'd1;
                        adv_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        err_index_d = index_q;
                        error_d     = 1'b1;
                        state_d     = ST_ERROR;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 32'(GAP_CLKS - 1)) begin
                    if (adv_q) begin
                        do_adv = 1'b1;
                    end else begin
                        cmd_valid_d = 1'b1;
                        state_d     = ST_ISSUE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_DELAY: begin
                if (cnt_q == '0) do_adv = 1'b1;
                else             cnt_d  = cnt_q - 32'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        // The last table slot ends the run even without an END marker.
        if (do_adv) begin
            if (&index_q) begin
                done_d  = 1'b1;
                state_d = ST_DONE;
            end else begin
                index_d = index_q + ADDR_W'(1);
                state_d = ST_FETCH;
            end
        end

        busy_d = !(state_d inside {ST_IDLE, ST_DONE, ST_ERROR});
    end

    always_ff @(posedge sda_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_reg_q   <= '0;
            cmd_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
            retry_q     <= '0;
            cnt_q       <= '0;
            adv_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_reg_q   <= cmd_reg_d;
            cmd_data_q  <= cmd_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
            retry_q     <= retry_d;
            cnt_q       <= cnt_d;
            adv_q       <= adv_d;
        end
    end

    assign tbl_addr     = index_q;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_dev_addr = DEV_ADDR;
    assign cmd_reg      = cmd_reg_q;
    assign cmd_data     = cmd_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_index    = err_index_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer: expected commands are queued when a run
// is started and popped as the DUT hands each command to the engine model.
module tb_i2c_init_sequencer;

    localparam int ADDR_W = 6;
    localparam int GAP    = 4;

    localparam logic [1023:0] IMG_A = {{61{16'hFFFF}}, 16'hFFFF, 16'h9803, 16'h4110};
    localparam logic [1023:0] IMG_B = {{61{16'hFFFF}}, 16'hFFFF, 16'h4110, 16'hFE05};
    localparam logic [1023:0] IMG_C = {{60{16'hFFFF}}, 16'hFFFF, 16'h55AA, 16'h9803, 16'h4110};

    logic              sda_clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] tbl_addr;
    logic [15:0]       tbl_data, rom_a, rom_b, rom_c;
    logic              cmd_valid;
    logic              cmd_ready = 1'b0;
    logic [6:0]        cmd_dev_addr;
    logic [7:0]        cmd_reg, cmd_data;
    logic              rsp_valid = 1'b0;
    logic              rsp_nack = 1'b0;
    logic              busy, done, error;
    logic [ADDR_W-1:0] err_index;

    int          sel = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          start_cyc, vld_cyc, acc_cyc, prev_acc;
    logic [15:0] exp_q[$];

    always #5 sda_clk = ~sda_clk;
    always @(posedge sda_clk) cyc <= cyc + 1;

    i2c_init_rom #(.ADDR_W(ADDR_W), .IMAGE(IMG_A)) u_rom_a (.sda_clk(sda_clk), .addr(tbl_addr), .data(rom_a));
    i2c_init_rom #(.ADDR_W(ADDR_W), .IMAGE(IMG_B)) u_rom_b (.sda_clk(sda_clk), .addr(tbl_addr), .data(rom_b));
    i2c_init_rom #(.ADDR_W(ADDR_W), .IMAGE(IMG_C)) u_rom_c (.sda_clk(sda_clk), .addr(tbl_addr), .data(rom_c));

    assign tbl_data = (sel == 1) ? rom_b : (sel == 2) ? rom_c : rom_a;

    i2c_init_sequencer #(
        .DEV_ADDR(7'h39), .ADDR_W(ADDR_W), .GAP_CLKS(GAP), .DELAY_UNIT(2),
        .MAX_RETRIES(2), .RSP_TIMEOUT(50)
    ) dut (
        .sda_clk(sda_clk), .reset(reset), .start(start),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev_addr(cmd_dev_addr),
        .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
        .busy(busy), .done(done), .error(error), .err_index(err_index)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sda_clk);
    endtask

    task automatic pulse_start();
        @(negedge sda_clk) start = 1'b1;
        @(negedge sda_clk) start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_tbl_addr"}, 32'(tbl_addr), 0);
        chk({tag, "_cmd_valid"}, 32'(cmd_valid), 0);
        chk({tag, "_cmd_payload"}, {16'h0, cmd_reg, cmd_data}, 0);
        chk({tag, "_flags"}, {29'h0, busy, done, error}, 0);
        chk({tag, "_err_index"}, 32'(err_index), 0);
    endtask

    // Engine model: optional ready stall, accept, then respond after rsp_dly
    // cycles (negative rsp_dly = never respond).
    task automatic exchange(input int stall, input int rsp_dly, input bit nack);
        int          n;
        logic [15:0] pl, ex;
        n = 0;
        while (!cmd_valid && n < 1000) begin
            @(negedge sda_clk);
            n++;
        end
        if (!cmd_valid) begin
            chk("cmd_valid_timeout", 0, 1);
            return;
        end
        vld_cyc = cyc;
        pl = {cmd_reg, cmd_data};
        for (int i = 0; i < stall; i++) begin
            @(negedge sda_clk);
            chk("stall_valid", 32'(cmd_valid), 1);
            chk("stall_payload", 32'({cmd_reg, cmd_data}), 32'(pl));
        end
        cmd_ready = 1'b1;
        @(negedge sda_clk) cmd_ready = 1'b0;
        prev_acc = acc_cyc;
        acc_cyc = cyc;
        chk("valid_drop", 32'(cmd_valid), 0);
        chk("cmd_dev", 32'(cmd_dev_addr), 32'h39);
        chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            chk("cmd_payload", 32'(pl), 32'(ex));
        end
        if (rsp_dly >= 0) begin
            tick(rsp_dly);
            rsp_valid = 1'b1;
            rsp_nack  = nack;
            @(negedge sda_clk);
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
        end
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || error) && n < 3000) begin
            @(negedge sda_clk);
            n++;
        end
        chk("run_end_timeout", 32'(done || error), 1);
    endtask

    task automatic quiet(input string tag, input int n);
        int hits;
        hits = 0;
        repeat (n) begin
            @(negedge sda_clk);
            if (cmd_valid) hits++;
        end
        chk(tag, hits, 0);
    endtask

    initial begin
        acc_cyc = 0;
        tick(3);
        check_reset_vals("rst_held");
        reset = 1'b0;
        tick(3);
        check_reset_vals("rst_idle");

        // Two writes, always ACKed.
        sel = 0;
        exp_q.push_back(16'h4110);
        exp_q.push_back(16'h9803);
        pulse_start();
        chk("t1_busy", 32'(busy), 1);
        exchange(0, 3, 0);
        exchange(0, 2, 0);
        chk("t1_gap", 32'((vld_cyc - prev_acc) >= GAP + 1), 1);
        wait_end();
        chk("t1_flags", {29'h0, busy, done, error}, 32'b010);
        quiet("t1_no_extra", 30);
        chk("t1_sb_empty", exp_q.size(), 0);

        // Engine stalls cmd_ready for 20 cycles.
        exp_q.push_back(16'h4110);
        exp_q.push_back(16'h9803);
        pulse_start();
        chk("t2_done_clr", 32'(done), 0);
        exchange(20, 1, 0);
        exchange(0, 1, 0);
        wait_end();
        chk("t2_flags", {29'h0, busy, done, error}, 32'b010);
        quiet("t2_no_dup", 20);
        chk("t2_sb_empty", exp_q.size(), 0);

        // Entry 1 NACKed twice, then ACKed; entry 2 follows.
        sel = 2;
        exp_q.push_back(16'h4110);
        repeat (3) exp_q.push_back(16'h9803);
        exp_q.push_back(16'h55AA);
        pulse_start();
        exchange(0, 2, 0);
        exchange(0, 2, 1);
        exchange(0, 2, 1);
        exchange(0, 2, 0);
        exchange(0, 2, 0);
        wait_end();
        chk("t3_flags", {29'h0, busy, done, error}, 32'b010);
        chk("t3_sb_empty", exp_q.size(), 0);

        // Entry 1 fails three times (last one by silence) -> error.
        exp_q.push_back(16'h4110);
        repeat (3) exp_q.push_back(16'h9803);
        pulse_start();
        exchange(0, 2, 0);
        exchange(0, 2, 1);
        exchange(0, 2, 1);
        exchange(0, -1, 0);
        wait_end();
        chk("t4_flags", {29'h0, busy, done, error}, 32'b001);
        chk("t4_err_index", 32'(err_index), 1);
        quiet("t4_no_more", 40);
        chk("t4_sb_empty", exp_q.size(), 0);
        exp_q.push_back(16'h4110);
        exp_q.push_back(16'h9803);
        exp_q.push_back(16'h55AA);
        pulse_start();
        chk("t4_err_clr", 32'(error), 0);
        repeat (3) exchange(0, 1, 0);
        wait_end();
        chk("t4_rerun_flags", {29'h0, busy, done, error}, 32'b010);

        // Leading delay entry of 5 ticks.
        sel = 1;
        exp_q.push_back(16'h4110);
        pulse_start();
        exchange(0, 1, 0);
        chk("t5_delay", 32'((acc_cyc - start_cyc) >= 12), 1);
        wait_end();
        chk("t5_flags", {29'h0, busy, done, error}, 32'b010);
        quiet("t5_single", 20);

        // Reset while waiting for a response.
        sel = 0;
        exp_q.push_back(16'h4110);
        pulse_start();
        exchange(0, -1, 0);
        tick(3);
        reset = 1'b1;
        tick(2);
        check_reset_vals("t6_rst");
        reset = 1'b0;
        tick(1);
        rsp_valid = 1'b1;
        @(negedge sda_clk) rsp_valid = 1'b0;
        quiet("t6_ignore_rsp", 10);
        check_reset_vals("t6_after");
        exp_q.push_back(16'h4110);
        exp_q.push_back(16'h9803);
        pulse_start();
        exchange(0, 1, 0);
        exchange(0, 1, 0);
        wait_end();
        chk("t6_flags", {29'h0, busy, done, error}, 32'b010);
        chk("t6_sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
